pulse_arbiter: RTL

- Shares one programmable-length pulse generator among NREQ requesters.
- Detects a rising edge on each requester's req line and latches it as pending.
- Grants pending requests round-robin and drives a single pulse_out high for that requester's configured length.
- Sits between the trigger sources and the shared actuator/strobe line; also owns the per-requester length registers.

---
 rtl/pulse_arbiter_if.sv | 39 +++
 rtl/pulse_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pulse_arbiter_if.sv
// Bus bundle for pulse_arbiter: request lines, length-register write port and pulse/status outputs.
// PULSE_ARB_DROP_CNT_EN adds the drop_cnt / drop_clr pair.
interface pulse_arbiter_if #(
    parameter int NREQ = 4,
    parameter int LW   = 16,
    parameter int SELW = 2
);
    logic [NREQ-1:0] req;
    logic            cfg_wr;
    logic [SELW-1:0] cfg_sel;
    logic [LW-1:0]   cfg_len;
    logic            pulse_out;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] done;
    logic            busy;
    logic [NREQ-1:0] pending;
`ifdef PULSE_ARB_DROP_CNT_EN
    logic [7:0]      drop_cnt;
    logic            drop_clr;

    modport master (
        output req, cfg_wr, cfg_sel, cfg_len, drop_clr,
        input  pulse_out, grant, done, busy, pending, drop_cnt
    );
    modport slave (
        input  req, cfg_wr, cfg_sel, cfg_len, drop_clr,
        output pulse_out, grant, done, busy, pending, drop_cnt
    );
`else
    modport master (
        output req, cfg_wr, cfg_sel, cfg_len,
        input  pulse_out, grant, done, busy, pending
    );
    modport slave (
        input  req, cfg_wr, cfg_sel, cfg_len,
        output pulse_out, grant, done, busy, pending
    );
`endif
endinterface

// File: rtl/pulse_arbiter.sv
// Round-robin sharing of one programmable-length pulse generator among NREQ edge-triggered requesters.
// Optional merged-edge counter (drop_cnt/drop_clr) is compiled in with PULSE_ARB_DROP_CNT_EN.
module pulse_arbiter #(
    parameter int NREQ        = 4,
    parameter int LW          = 16,
    parameter int DEFAULT_LEN = 5,
    parameter int SELW        = 2
) (
    input  logic           clk,
    input  logic           rst,
    pulse_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

    state_t          r_state, w_state_next;
    logic [NREQ-1:0] r_req_q, r_pending;
    logic [NREQ-1:0] w_rise, w_take_mask, w_owner_hot;
    logic [LW-1:0]   r_len [NREQ];
    logic [LW-1:0]   r_cnt, w_win_len;
    logic [IW-1:0]   r_owner, r_rr_last, w_win;
    logic            w_found, w_take;

    assign w_rise = bus.req & ~r_req_q;

    // Round-robin scan starting just after the last winner, wrapping back to it.
    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] idx;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_found = 1'b0;
        w_win   = '0;
        sum     = '0;
        idx     = '0;
        for (int off = 1; off <= NREQ; off++) begin
            sum = {1'b0, r_rr_last} + (IW+1)'(off);
            if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
            idx = sum[IW-1:0];
            if (!w_found && r_pending[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    assign w_take    = (r_state == S_IDLE) && w_found;
    assign w_win_len = r_len[w_win];

    always_comb begin
        w_take_mask = '0;
        w_owner_hot = '0;
        if (w_take) w_take_mask[w_win] = 1'b1;
        w_owner_hot[r_owner] = 1'b1;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_found) w_state_next = S_PULSE;
            S_PULSE: if (r_cnt == LW'(1)) w_state_next = S_GAP;
            S_GAP:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // A new rise on the winner in its grant cycle survives the clear (set wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_q   <= '0;
            r_pending <= '0;
        end else begin
            r_req_q   <= bus.req;
            r_pending <= (r_pending & ~w_take_mask) | w_rise;
        end
    end

    // Length is captured into r_cnt at grant time, so later cfg writes do not disturb a running pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_owner   <= '0;
            r_rr_last <= IW'(NREQ - 1);
        end else if (w_take) begin
            r_cnt     <= (w_win_len == '0) ? LW'(1) : w_win_len;
            r_owner   <= w_win;
            r_rr_last <= w_win;
        end else if (r_state == S_PULSE) begin
            r_cnt     <= r_cnt - LW'(1);
        end
    end

    // NOTE: this small register file is reset on purpose so every requester starts at DEFAULT_LEN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) r_len[i] <= LW'(DEFAULT_LEN);
        end else if (bus.cfg_wr) begin
            for (int i = 0; i < NREQ; i++)
                if (bus.cfg_sel == SELW'(i)) r_len[i] <= bus.cfg_len;
        end
    end

    assign bus.pulse_out = (r_state == S_PULSE);
    assign bus.grant     = (r_state == S_PULSE) ? w_owner_hot : '0;
    assign bus.done      = (r_state == S_GAP)   ? w_owner_hot : '0;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.pending   = r_pending;

`ifdef PULSE_ARB_DROP_CNT_EN
    logic [NREQ-1:0] w_drop;
    logic [8:0]      w_drop_sum;
    logic [7:0]      r_drop_cnt;

    // An edge on the bit being granted this cycle is not lost, so it is not counted.
    assign w_drop = w_rise & r_pending & ~w_take_mask;

    always_comb begin
        w_drop_sum = {1'b0, r_drop_cnt};
        for (int i = 0; i < NREQ; i++) w_drop_sum = w_drop_sum + 9'(w_drop[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_drop_cnt <= '0;
        else if (bus.drop_clr)       r_drop_cnt <= '0;
        else if (w_drop_sum > 9'd255) r_drop_cnt <= 8'hFF;
        else                         r_drop_cnt <= w_drop_sum[7:0];
    end

    assign bus.drop_cnt = r_drop_cnt;
`endif
endmodule
